// File: rtl/aes_pkg.sv
// Shared AES definitions: block type, field polynomial, S-box table,
// byte-level GF(2^8) helpers and the FIPS-197 round test vectors.
package aes_pkg;

  typedef logic [127:0] aes_block_t;

  // Low byte of the field polynomial x^8 + x^4 + x^3 + x + 1 (0x11B).
  localparam logic [7:0] AES_POLY = 8'h1B;

  // FIPS-197 Appendix B: round 1 (middle round) and round 10 (final round).
  localparam aes_block_t AES_TV_MID_STATE = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam aes_block_t AES_TV_MID_KEY   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam aes_block_t AES_TV_MID_OUT   = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam aes_block_t AES_TV_FIN_STATE = 128'heb40f21e592e38848ba113e71bc342d2;
  localparam aes_block_t AES_TV_FIN_KEY   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam aes_block_t AES_TV_FIN_OUT   = 128'h3925841d02dc09fbdc118597196a0b32;

  // Forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] AES_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] aes_sbox(input logic [7:0] b);
    int idx;
    idx = 255 - int'(b);
    return AES_SBOX[idx*8 +: 8];
  endfunction

  // Multiply by x in GF(2^8).
  function automatic logic [7:0] aes_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_pipe_slot.sv
// One pipeline register slot with a valid bit and valid/ready flow control.
// The slot accepts when empty or when its content leaves this cycle; a
// synchronous clear empties it and blocks acceptance for that cycle.
module aes_pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_r;
  logic [W-1:0] data_r;
  logic         ready_s;
  logic         load_s;

  // Readiness: free slot or draining slot, unless being cleared.
  always_comb begin
    ready_s = 1'b0;
    if (clear) begin
      ready_s = 1'b0;
    end else begin
      ready_s = ~valid_r | out_ready;
    end
    load_s = in_valid & ready_s;
  end

  // Valid bit: clear wins, otherwise refill or empty whenever the slot moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
    end else if (clear) begin
      valid_r <= 1'b0;
    end else if (ready_s) begin
      valid_r <= in_valid;
    end else begin
      valid_r <= valid_r;
    end
  end

  // Payload: load only on an accepted block, otherwise hold (never zeroed).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r <= {W{1'b0}};
    end else if (load_s) begin
      data_r <= in_data;
    end else begin
      data_r <= data_r;
    end
  end

  assign in_ready  = ready_s;
  assign out_valid = valid_r;
  assign out_data  = data_r;

endmodule

// File: rtl/aes_round_ops.sv
// Combinational AES round transforms shared by the round cores:
// subBytes, shiftRows, mixColumns and addRoundKey. Byte k of a state
// sits at [127-8k -: 8]; byte k is row k%4, column k/4.

module subBytes
  import aes_pkg::*;
(
  input  aes_block_t in_state,
  output aes_block_t out_state
);

  // Substitute every byte through the S-box.
  always_comb begin
    out_state = 128'h0;
    for (int k = 0; k < 16; k++) begin
      out_state[127-8*k -: 8] = aes_sbox(in_state[127-8*k -: 8]);
    end
  end

endmodule

module shiftRows
  import aes_pkg::*;
(
  input  aes_block_t in_state,
  output aes_block_t out_state
);

  // Rotate row r left by r byte positions.
  always_comb begin
    out_state = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        out_state[127-8*(4*c+r) -: 8] = in_state[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
  end

endmodule

module mixColumns
  import aes_pkg::*;
(
  input  aes_block_t in_state,
  output aes_block_t out_state
);

  // Multiply one column by the circulant matrix {02,03,01,01}.
  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {aes_xtime(a0) ^ aes_xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ aes_xtime(a1) ^ aes_xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ aes_xtime(a2) ^ aes_xtime(a3) ^ a3,
            aes_xtime(a0) ^ a0 ^ a1 ^ a2 ^ aes_xtime(a3)};
  endfunction

  // Mix each of the four columns independently.
  always_comb begin
    out_state = 128'h0;
    for (int c = 0; c < 4; c++) begin
      out_state[127-32*c -: 32] = mix_col(in_state[127-32*c -: 32]);
    end
  end

endmodule

module addRoundKey
  import aes_pkg::*;
(
  input  aes_block_t in_state,
  input  aes_block_t in_key,
  output aes_block_t out_state
);

  assign out_state = in_state ^ in_key;

endmodule

// File: rtl/aes_round_pipe.sv
// Pipelined AES encryption round (SubBytes, ShiftRows, optional MixColumns,
// AddRoundKey) behind a valid/ready handshake. PIPE_STAGES selects one or
// two register stages; in_last bypasses MixColumns for the final round.
// Optional feature macro: AES_ROUND_FLUSH_EN adds a synchronous flush input.
module aes_round_pipe
  import aes_pkg::*;
#(
  parameter int PIPE_STAGES = 1,
  parameter int TAG_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef AES_ROUND_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  aes_block_t       in_state,
  input  aes_block_t       in_key,
  input  logic             in_last,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output aes_block_t       out_state,
  output logic [TAG_W-1:0] out_tag
);

  logic       flush_s;
  aes_block_t sb_s;
  aes_block_t sr_s;
  aes_block_t back_in_s;
  aes_block_t back_key_s;
  logic       back_last_s;
  aes_block_t mix_s;
  aes_block_t mc_sel_s;
  aes_block_t ark_s;

`ifdef AES_ROUND_FLUSH_EN
  assign flush_s = flush;
`else
  assign flush_s = 1'b0;
`endif

  // Front half always works on the incoming block.
  subBytes u_sub (
    .in_state  (in_state),
    .out_state (sb_s)
  );

  shiftRows u_shift (
    .in_state  (sb_s),
    .out_state (sr_s)
  );

  // Back half works on the incoming block (one stage) or the stage-0 content.
  mixColumns u_mix (
    .in_state  (back_in_s),
    .out_state (mix_s)
  );

  // Final round skips MixColumns.
  always_comb begin
    mc_sel_s = mix_s;
    if (back_last_s) begin
      mc_sel_s = back_in_s;
    end else begin
      mc_sel_s = mix_s;
    end
  end

  addRoundKey u_ark (
    .in_state  (mc_sel_s),
    .in_key    (back_key_s),
    .out_state (ark_s)
  );

  generate
    if (PIPE_STAGES == 1) begin : g_one_stage
      localparam int OW = 128 + TAG_W;
      logic [OW-1:0] out_data_s;

      assign back_in_s   = sr_s;
      assign back_key_s  = in_key;
      assign back_last_s = in_last;

      aes_pipe_slot #(.W(OW)) u_slot0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (flush_s),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({ark_s, in_tag}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data_s)
      );

      assign out_state = out_data_s[OW-1 -: 128];
      assign out_tag   = out_data_s[TAG_W-1:0];
    end else begin : g_two_stage
      // Stage 0 payload: {shifted state, key, last, tag}.
      localparam int MW = 128 + 128 + 1 + TAG_W;
      localparam int OW = 128 + TAG_W;
      logic [MW-1:0] mid_data_s;
      logic          mid_valid_s;
      logic          mid_ready_s;
      logic [OW-1:0] out_data_s;

      aes_pipe_slot #(.W(MW)) u_slot0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (flush_s),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({sr_s, in_key, in_last, in_tag}),
        .out_valid (mid_valid_s),
        .out_ready (mid_ready_s),
        .out_data  (mid_data_s)
      );

      assign back_in_s   = mid_data_s[MW-1 -: 128];
      assign back_key_s  = mid_data_s[MW-129 -: 128];
      assign back_last_s = mid_data_s[TAG_W];

      aes_pipe_slot #(.W(OW)) u_slot1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (flush_s),
        .in_valid  (mid_valid_s),
        .in_ready  (mid_ready_s),
        .in_data   ({ark_s, mid_data_s[TAG_W-1:0]}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data_s)
      );

      assign out_state = out_data_s[OW-1 -: 128];
      assign out_tag   = out_data_s[TAG_W-1:0];
    end
  endgenerate

endmodule

// File: tb/tb_aes_round_pipe.sv
// Bench for aes_round_pipe: instance 0 with PIPE_STAGES=1, instance 1 with
// PIPE_STAGES=2, each with its own handshake signals. A reference round
// built from GF(2^8) arithmetic (S-box from inversion + affine map) feeds a
// per-instance scoreboard checked by one compare process on every negedge.
module tb_aes_round_pipe;
  import aes_pkg::*;

  localparam int TAG_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  logic             in_valid_a [2];
  aes_block_t       in_state_a [2];
  aes_block_t       in_key_a   [2];
  logic             in_last_a  [2];
  logic [TAG_W-1:0] in_tag_a   [2];
  logic             out_ready_a[2];
  logic             in_ready_a [2];
  logic             out_valid_a[2];
  aes_block_t       out_state_a[2];
  logic [TAG_W-1:0] out_tag_a  [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aes_round_pipe #(.PIPE_STAGES(1), .TAG_W(TAG_W)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
`ifdef AES_ROUND_FLUSH_EN
    .flush(flush),
`endif
    .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]), .in_state(in_state_a[0]),
    .in_key(in_key_a[0]), .in_last(in_last_a[0]), .in_tag(in_tag_a[0]),
    .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]),
    .out_state(out_state_a[0]), .out_tag(out_tag_a[0])
  );

  aes_round_pipe #(.PIPE_STAGES(2), .TAG_W(TAG_W)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
`ifdef AES_ROUND_FLUSH_EN
    .flush(flush),
`endif
    .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]), .in_state(in_state_a[1]),
    .in_key(in_key_a[1]), .in_last(in_last_a[1]), .in_tag(in_tag_a[1]),
    .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]),
    .out_state(out_state_a[1]), .out_tag(out_tag_a[1])
  );

  // ---------------- reference model ----------------
  logic [7:0] sbox_tab[256];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
      end
      sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic aes_block_t ref_round(input aes_block_t s, input aes_block_t key, input logic last);
    logic [7:0] sb[4][4];
    logic [7:0] sh[4][4];
    logic [7:0] o[4][4];
    logic [7:0] cf;
    aes_block_t res;
    res = 128'h0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sb[r][c] = sbox_tab[s[127-8*(4*c+r) -: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sh[r][c] = sb[r][(c+r)%4];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        if (last) o[r][c] = sh[r][c];
        else begin
          o[r][c] = 8'h00;
          for (int j = 0; j < 4; j++) begin
            cf = ((j - r + 4) % 4 == 0) ? 8'h02 : (((j - r + 4) % 4 == 1) ? 8'h03 : 8'h01);
            o[r][c] = o[r][c] ^ gmul(cf, sh[j][c]);
          end
        end
        res[127-8*(4*c+r) -: 8] = o[r][c];
      end
    return res ^ key;
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input int d, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h", nm, d, act, exp);
    end
  endtask

  function automatic aes_block_t rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic put_block(input int d, input logic [TAG_W-1:0] tag);
    in_state_a[d] = rand128();
    in_key_a[d]   = rand128();
    in_last_a[d]  = 1'($urandom_range(0, 1));
    in_tag_a[d]   = tag;
  endtask

  // ---------------- scoreboard / compare process ----------------
  typedef struct {
    aes_block_t       st;
    logic [TAG_W-1:0] tg;
  } exp_t;

  exp_t             sb_q[2][$];
  int               rx_cnt[2];
  logic             hold_p[2];
  aes_block_t       hold_st[2];
  logic [TAG_W-1:0] hold_tg[2];

  initial begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      rx_cnt[d] = 0; hold_p[d] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!rst_n || flush) begin
          sb_q[d].delete();
          hold_p[d] = 1'b0;
        end else begin
          if (hold_p[d]) begin
            chk("stall_valid", d, 128'(out_valid_a[d]), 128'd1);
            chk("stall_state", d, out_state_a[d], hold_st[d]);
            chk("stall_tag", d, 128'(out_tag_a[d]), 128'(hold_tg[d]));
          end
          if (out_valid_a[d] && out_ready_a[d]) begin
            if (sb_q[d].size() == 0) begin
              chk("unexpected_output", d, 128'd1, 128'd0);
            end else begin
              e = sb_q[d].pop_front();
              chk("out_state", d, out_state_a[d], e.st);
              chk("out_tag", d, 128'(out_tag_a[d]), 128'(e.tg));
              rx_cnt[d]++;
            end
          end
          if (in_valid_a[d] && in_ready_a[d]) begin
            e.st = ref_round(in_state_a[d], in_key_a[d], in_last_a[d]);
            e.tg = in_tag_a[d];
            sb_q[d].push_back(e);
          end
          hold_p[d]  = out_valid_a[d] & ~out_ready_a[d];
          hold_st[d] = out_state_a[d];
          hold_tg[d] = out_tag_a[d];
        end
      end
    end
  end

  // ---------------- directed / random tasks ----------------
  // One block into both instances with no stall; check the exact latency.
  task automatic latency_test(input string nm, input aes_block_t s, input aes_block_t k,
                              input logic last, input logic [TAG_W-1:0] tag, input aes_block_t exp);
    for (int d = 0; d < 2; d++) begin
      in_valid_a[d] = 1'b1; in_state_a[d] = s; in_key_a[d] = k;
      in_last_a[d] = last; in_tag_a[d] = tag; out_ready_a[d] = 1'b1;
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk({nm, "_in_ready"}, d, 128'(in_ready_a[d]), 128'd1);
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) in_valid_a[d] = 1'b0;
    chk({nm, "_lat1_valid"}, 0, 128'(out_valid_a[0]), 128'd1);
    chk({nm, "_lat1_state"}, 0, out_state_a[0], exp);
    chk({nm, "_lat1_tag"}, 0, 128'(out_tag_a[0]), 128'(tag));
    chk({nm, "_lat2_early"}, 1, 128'(out_valid_a[1]), 128'd0);
    @(posedge clk); #1;
    chk({nm, "_lat2_valid"}, 1, 128'(out_valid_a[1]), 128'd1);
    chk({nm, "_lat2_state"}, 1, out_state_a[1], exp);
    chk({nm, "_lat2_tag"}, 1, 128'(out_tag_a[1]), 128'(tag));
    chk({nm, "_lat1_drained"}, 0, 128'(out_valid_a[0]), 128'd0);
    @(posedge clk); #1;
  endtask

  // Stream n blocks with random gaps and random backpressure (optionally
  // with five consecutive out_ready-low cycles early on).
  task automatic run_stream(input int d, input int n, input int tag0, input bit force_gap);
    int  sent, k, rx0;
    bit  pending;
    sent = 0; k = 0; rx0 = rx_cnt[d]; pending = 1'b0;
    while ((sent < n || rx_cnt[d] - rx0 < n) && k < 400) begin
      if (force_gap && k >= 2 && k < 7) out_ready_a[d] = 1'b0;
      else if (k >= 40) out_ready_a[d] = 1'b1;
      else out_ready_a[d] = 1'($urandom_range(0, 1));
      if (sent < n) begin
        if (!pending) begin
          put_block(d, 4'((tag0 + sent) % 16));
          in_valid_a[d] = force_gap ? 1'b1 : ($urandom_range(0, 3) != 0);
        end
      end else begin
        in_valid_a[d] = 1'b0;
      end
      @(negedge clk);
      if (in_valid_a[d] && in_ready_a[d]) begin
        sent++;
        pending = 1'b0;
      end else begin
        pending = in_valid_a[d];
      end
      @(posedge clk); #1;
      k++;
    end
    in_valid_a[d] = 1'b0;
    out_ready_a[d] = 1'b1;
    chk("stream_count", d, 128'(rx_cnt[d] - rx0), 128'(n));
  endtask

  // Push blocks with out_ready=0 until the instance stalls or max_n accepted.
  task automatic fill(input int d, input int max_n, output int n);
    bit acc;
    n = 0;
    out_ready_a[d] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      in_valid_a[d] = 1'b1;
      put_block(d, 4'(k));
      @(negedge clk);
      acc = in_ready_a[d];
      @(posedge clk); #1;
      if (acc) n++;
      if (!acc || n >= max_n) break;
    end
    in_valid_a[d] = 1'b0;
  endtask

  task automatic full_test(input int d);
    int n;
    fill(d, 8, n);
    chk("full_depth", d, 128'(n), 128'(d + 1));
    in_valid_a[d] = 1'b1;
    put_block(d, 4'hA);
    @(negedge clk);
    chk("full_in_ready_low", d, 128'(in_ready_a[d]), 128'd0);
    @(posedge clk); #1;
    out_ready_a[d] = 1'b1;
    @(negedge clk);
    chk("simul_in_xfer", d, 128'(in_ready_a[d]), 128'd1);
    chk("simul_out_xfer", d, 128'(out_valid_a[d]), 128'd1);
    @(posedge clk); #1;
    in_valid_a[d] = 1'b0;
    chk("simul_still_full", d, 128'(out_valid_a[d]), 128'd1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    for (int d = 0; d < 2; d++) begin
      in_valid_a[d] = 1'b0; in_state_a[d] = 128'h0; in_key_a[d] = 128'h0;
      in_last_a[d] = 1'b0; in_tag_a[d] = 4'h0; out_ready_a[d] = 1'b1;
    end
    build_sbox();

    // Model pins against FIPS-197 values.
    chk("model_sbox_00", 0, 128'(sbox_tab[8'h00]), 128'h63);
    chk("model_sbox_53", 0, 128'(sbox_tab[8'h53]), 128'hed);
    chk("model_mid", 0, ref_round(AES_TV_MID_STATE, AES_TV_MID_KEY, 1'b0), AES_TV_MID_OUT);
    chk("model_fin", 0, ref_round(AES_TV_FIN_STATE, AES_TV_FIN_KEY, 1'b1), AES_TV_FIN_OUT);

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_out_valid", d, 128'(out_valid_a[d]), 128'd0);
      chk("rst_out_state", d, out_state_a[d], 128'h0);
      chk("rst_out_tag", d, 128'(out_tag_a[d]), 128'd0);
      chk("rst_in_ready", d, 128'(in_ready_a[d]), 128'd1);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    latency_test("mid", AES_TV_MID_STATE, AES_TV_MID_KEY, 1'b0, 4'h5, 128'ha49c7ff2689f352b6b5bea43026a5049);
    latency_test("fin", AES_TV_FIN_STATE, AES_TV_FIN_KEY, 1'b1, 4'h9, 128'h3925841d02dc09fbdc118597196a0b32);

    // Backpressure: tags 0..7 with a forced 5-cycle out_ready gap.
    fork
      run_stream(0, 8, 0, 1'b1);
      run_stream(1, 8, 0, 1'b1);
    join

    full_test(0);
    full_test(1);

    // Asynchronous reset mid-cycle with blocks in flight.
    fill(0, 2, n);
    fill(1, 2, n);
    chk("rst_inflight_pre", 1, 128'(out_valid_a[1]), 128'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("arst_out_valid", d, 128'(out_valid_a[d]), 128'd0);
      chk("arst_out_state", d, out_state_a[d], 128'h0);
      chk("arst_in_ready", d, 128'(in_ready_a[d]), 128'd1);
      out_ready_a[d] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) chk("post_rst_no_output", d, 128'(out_valid_a[d]), 128'd0);
    end
    for (int d = 0; d < 2; d++) chk("post_rst_in_ready", d, 128'(in_ready_a[d]), 128'd1);

    // Longer randomized traffic.
    fork
      run_stream(0, 40, 3, 1'b0);
      run_stream(1, 40, 3, 1'b0);
    join

`ifdef AES_ROUND_FLUSH_EN
    fill(0, 8, n);
    fill(1, 8, n);
    for (int d = 0; d < 2; d++) begin
      in_valid_a[d] = 1'b1;
      put_block(d, 4'hF);
    end
    flush = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk("flush_in_ready", d, 128'(in_ready_a[d]), 128'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_valid_a[d] = 1'b0;
      chk("flush_out_valid", d, 128'(out_valid_a[d]), 128'd0);
      chk("flush_in_ready_after", d, 128'(in_ready_a[d]), 128'd1);
      out_ready_a[d] = 1'b1;
    end
    repeat (4) @(posedge clk);
    #1;
`endif

    for (int d = 0; d < 2; d++) chk("scoreboard_empty", d, 128'(sb_q[d].size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
